pipelined_select_adder: RTL and testbench

Parametrised, two-stage pipelined carry-select adder/subtractor for the fixed-point datapath, with valid/ready flow control, optional saturation and a full flag set (carry, overflow, negative, zero). It generalises the combinational carry-select adder in width, block size and mode (add/sub, wrap/saturate), and adds registered pipelining so it can sit between the ODE solver's multiply and accumulate stages at full clock rate.

---
 rtl/pipelined_select_adder.sv | 126 ++++++++++++
 tb/tb_pipelined_select_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_select_adder.sv
// pipelined_select_adder: two-stage carry-select adder/subtractor with valid/ready flow control, saturation and flags
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid_i / in_ready_o          operand handshake
//   a_i, b_i [N-1:0]                 two's complement operands
//   cin_i, sub_i, sat_i              carry/borrow in, subtract select, saturate enable
//   out_valid_o / out_ready_i        result handshake
//   result_o [N-1:0]                 wrapped or saturated sum/difference
//   carry_o, overflow_o, negative_o  raw-operation flags
//   zero_o                           result_o == 0 after saturation
module pipelined_select_adder #(
   parameter int N     = 16,
   parameter int BLOCK = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         cin_i,
   input  logic         sub_i,
   input  logic         sat_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [N-1:0] result_o,
   output logic         carry_o,
   output logic         overflow_o,
   output logic         negative_o,
   output logic         zero_o
);
   localparam int H   = N / 2;
   localparam int NBH = H / BLOCK;
   localparam int NB  = N / BLOCK;
   logic [N-1:0] bx;
   logic c0;
   logic [NB-1:0][BLOCK:0] s0, s1;
   logic [H-1:0] lo_d, lo_q;
   logic chi_d, chi_q;
   logic [1:0][H-1:0] up_d, up_q;
   logic [1:0] co_d, co_q, ci_d, ci_q;
   logic sat_q, v1_q, v2_q, adv1, adv2;
   logic [H-1:0] up_sel;
   logic [N-1:0] raw, result_d, result_q;
   logic carry_d, overflow_d, negative_d, zero_d;
   logic carry_q, overflow_q, negative_q, zero_q;
   assign bx = sub_i ? ~b_i : b_i;
   assign c0 = sub_i ^ cin_i;
   genvar g;
   for (g = 0; g < NB; g++) begin : g_blk
      assign s0[g] = {1'b0, a_i[g*BLOCK +: BLOCK]} + {1'b0, bx[g*BLOCK +: BLOCK]};
      assign s1[g] = {1'b0, a_i[g*BLOCK +: BLOCK]} + {1'b0, bx[g*BLOCK +: BLOCK]} + (BLOCK+1)'(1);
   end
   // Lower half resolves fully; the upper half is resolved for both possible carries into it.
   always_comb begin
      lo_d  = '0;
      chi_d = c0;
      up_d  = '0;
      co_d  = '0;
      ci_d  = '0;
      for (int i = 0; i < NBH; i++) begin
         lo_d[i*BLOCK +: BLOCK] = chi_d ? s1[i][BLOCK-1:0] : s0[i][BLOCK-1:0];
         chi_d = chi_d ? s1[i][BLOCK] : s0[i][BLOCK];
      end
      for (int k = 0; k < 2; k++) begin
         co_d[k] = k[0];
         for (int i = 0; i < NBH; i++) begin
            up_d[k][i*BLOCK +: BLOCK] = co_d[k] ? s1[NBH+i][BLOCK-1:0] : s0[NBH+i][BLOCK-1:0];
            co_d[k] = co_d[k] ? s1[NBH+i][BLOCK] : s0[NBH+i][BLOCK];
         end
         // Carry into the MSB recovered from the MSB sum bit and its operand bits.
         ci_d[k] = a_i[N-1] ^ bx[N-1] ^ up_d[k][H-1];
      end
   end
   assign adv2       = !v2_q || out_ready_i;
   assign adv1       = !v1_q || adv2;
   assign in_ready_o = adv1;
   assign up_sel     = chi_q ? up_q[1] : up_q[0];
   assign raw        = {up_sel, lo_q};
   assign carry_d    = co_q[chi_q];
   assign overflow_d = co_q[chi_q] ^ ci_q[chi_q];
   assign negative_d = raw[N-1] ^ overflow_d;
   assign result_d   = (sat_q && overflow_d) ? (negative_d ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : raw;
   assign zero_d     = result_d == '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         lo_q       <= '0;
         chi_q      <= 1'b0;
         up_q       <= '0;
         co_q       <= '0;
         ci_q       <= '0;
         sat_q      <= 1'b0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         negative_q <= 1'b0;
         zero_q     <= 1'b1;
      end else begin
         if (adv1) v1_q <= in_valid_i;
         if (in_valid_i && adv1) begin
            lo_q  <= lo_d;
            chi_q <= chi_d;
            up_q  <= up_d;
            co_q  <= co_d;
            ci_q  <= ci_d;
            sat_q <= sat_i;
         end
         if (adv2) v2_q <= v1_q;
         if (adv2 && v1_q) begin
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            negative_q <= negative_d;
            zero_q     <= zero_d;
         end
      end
   end
   assign out_valid_o = v2_q;
   assign result_o    = result_q;
   assign carry_o     = carry_q;
   assign overflow_o  = overflow_q;
   assign negative_o  = negative_q;
   assign zero_o      = zero_q;
endmodule

// File: tb/tb_pipelined_select_adder.sv
// tb_pipelined_select_adder: directed and randomised checks of pipelined_select_adder at 16/4 and 32/8
module tb_pipelined_select_adder;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic iv16 = 0, ir16, cin16 = 0, sub16 = 0, sat16 = 0, ov16v, ordy16 = 1, c16, o16, n16, z16;
   logic [15:0] a16 = 0, b16 = 0, r16;
   logic iv32 = 0, ir32, cin32 = 0, sub32 = 0, sat32 = 0, ov32v, ordy32 = 1, c32, o32, n32, z32;
   logic [31:0] a32 = 0, b32 = 0, r32;
   int checks = 0, errors = 0, acc32 = 0, run16 = 0, max16 = 0;
   logic [35:0] q16[$], q32[$];

   pipelined_select_adder #(.N(16), .BLOCK(4)) u16 (
      .clk(clk), .rst(rst), .in_valid_i(iv16), .in_ready_o(ir16), .a_i(a16), .b_i(b16),
      .cin_i(cin16), .sub_i(sub16), .sat_i(sat16), .out_valid_o(ov16v), .out_ready_i(ordy16),
      .result_o(r16), .carry_o(c16), .overflow_o(o16), .negative_o(n16), .zero_o(z16));
   pipelined_select_adder #(.N(32), .BLOCK(8)) u32 (
      .clk(clk), .rst(rst), .in_valid_i(iv32), .in_ready_o(ir32), .a_i(a32), .b_i(b32),
      .cin_i(cin32), .sub_i(sub32), .sat_i(sat32), .out_valid_o(ov32v), .out_ready_i(ordy32),
      .result_o(r32), .carry_o(c32), .overflow_o(o32), .negative_o(n32), .zero_o(z32));

   // Reference: exact signed arithmetic decides overflow and sign; modular arithmetic gives raw result and carry.
   function automatic logic [35:0] model(int n, logic [31:0] a, logic [31:0] b, logic cin, logic sub, logic sat);
      longint mask, av, bv, bx, full, raw, sa, sb, ex, hi, lo, res;
      logic ov, ng;
      mask = (longint'(1) << n) - 1;
      av   = longint'(a) & mask;
      bv   = longint'(b) & mask;
      bx   = sub ? (~bv & mask) : bv;
      full = av + bx + longint'(sub ^ cin);
      raw  = full & mask;
      sa   = av[n-1] ? av - (mask + 1) : av;
      sb   = bv[n-1] ? bv - (mask + 1) : bv;
      ex   = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
      hi   = (longint'(1) << (n - 1)) - 1;
      lo   = -(hi + 1);
      ov   = ex > hi || ex < lo;
      ng   = ex < 0;
      res  = (sat && ov) ? (ng ? hi + 1 : hi) : raw;
      return {res[31:0], full[n], ov, ng, res == 0};
   endfunction

   function automatic logic [31:0] rnd(int n);
      logic [31:0] m;
      m = (n == 32) ? 32'hFFFF_FFFF : (32'd1 << n) - 1;
      case ($urandom % 8)
         0: return m >> 1;
         1: return (m >> 1) + 1;
         2: return 32'd0;
         3: return m;
         default: return $urandom & m;
      endcase
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         q16.delete();
         q32.delete();
         run16 = 0;
      end else begin
         if (ov16v) begin
            run16++;
            if (run16 > max16) max16 = run16;
            chk("q16_nonempty", 64'(q16.size() != 0), 64'd1);
            if (q16.size() != 0) begin
               chk("out16", {16'b0, r16, c16, o16, n16, z16}, q16[0]);
               if (ordy16) void'(q16.pop_front());
            end
         end else run16 = 0;
         if (iv16 && ir16) q16.push_back(model(16, {16'b0, a16}, {16'b0, b16}, cin16, sub16, sat16));
         if (ov32v) begin
            chk("q32_nonempty", 64'(q32.size() != 0), 64'd1);
            if (q32.size() != 0) begin
               chk("out32", {r32, c32, o32, n32, z32}, q32[0]);
               if (ordy32) void'(q32.pop_front());
            end
         end
         if (iv32 && ir32) begin
            q32.push_back(model(32, a32, b32, cin32, sub32, sat32));
            acc32++;
         end
      end
   end

   task automatic op16(logic [15:0] a, logic [15:0] b, logic cin, logic sub, logic sat);
      int t = 0;
      a16 = a; b16 = b; cin16 = cin; sub16 = sub; sat16 = sat; iv16 = 1;
      while (!ir16 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk("accept16", 64'(ir16), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_out16(string nm, logic [19:0] exp, output int t);
      t = 0;
      @(negedge clk);
      while (!ov16v && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_valid"}, 64'(ov16v), 64'd1);
      if (ov16v) chk(nm, {r16, c16, o16, n16, z16}, exp);
   endtask

   initial begin
      int t, seen, cyc;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk("rst16", {ov16v, ir16, r16, c16, o16, n16, z16}, {1'b0, 1'b1, 16'h0, 4'b0001});
      chk("rst32", {ov32v, ir32, r32, c32, o32, n32, z32}, {1'b0, 1'b1, 32'h0, 4'b0001});
      op16(16'h7FFF, 16'h0001, 0, 0, 0); iv16 = 0;
      wait_out16("wrap", {16'h8000, 4'b0100}, t);
      chk("latency", 64'(t), 64'd1);
      @(posedge clk); #1;
      op16(16'h7FFF, 16'h0001, 0, 0, 1); iv16 = 0;
      wait_out16("sat_pos", {16'h7FFF, 4'b0100}, t);
      @(posedge clk); #1;
      op16(16'h8000, 16'h0001, 0, 1, 1); iv16 = 0;
      wait_out16("sat_neg", {16'h8000, 4'b1110}, t);
      @(posedge clk); #1;
      op16(16'h0005, 16'h0005, 0, 1, 0); iv16 = 0;
      wait_out16("sub_zero", {16'h0000, 4'b1001}, t);
      @(posedge clk); #1;
      op16(16'h0005, 16'h0005, 1, 1, 0); iv16 = 0;
      wait_out16("sub_borrow", {16'hFFFF, 4'b0010}, t);
      @(posedge clk); #1;
      max16 = 0;
      for (int i = 0; i < 4; i++) op16(16'(i * 1234 + 77), 16'(i * 4321 + 9), i[0], i[1], 0);
      iv16 = 0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("b2b_run", 64'(max16), 64'd4);
      chk("b2b_drain", 64'(q16.size()), 64'd0);
      ordy16 = 0;
      op16(16'h1111, 16'h2222, 0, 0, 0);
      op16(16'h7000, 16'h7000, 1, 0, 1);
      chk("bp_ready", 64'(ir16), 64'd0);
      fork
         op16(16'h0100, 16'hFF00, 0, 1, 0);
         begin
            repeat (3) begin
               @(posedge clk); #1;
               chk("bp_hold", 64'(ir16), 64'd0);
            end
            ordy16 = 1;
         end
      join
      iv16 = 0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk("bp_drain", 64'(q16.size()), 64'd0);
      op16(16'h0042, 16'h0011, 0, 0, 0);
      op16(16'h8000, 16'h8000, 0, 0, 0);
      iv16 = 0;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("midrst", {ov16v, ir16, r16, c16, o16, n16, z16}, {1'b0, 1'b1, 16'h0, 4'b0001});
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         seen |= int'(ov16v);
      end
      chk("no_stale", 64'(seen), 64'd0);
      @(posedge clk); #1;
      cyc = 0;
      while (acc32 < 10000 && cyc < 60000) begin
         iv16 = ($urandom % 4) != 0;
         a16 = rnd(16)[15:0]; b16 = rnd(16)[15:0];
         cin16 = $urandom % 2; sub16 = $urandom % 2; sat16 = $urandom % 2;
         ordy16 = $urandom % 2;
         iv32 = ($urandom % 4) != 0;
         a32 = rnd(32); b32 = rnd(32);
         cin32 = $urandom % 2; sub32 = $urandom % 2; sat32 = $urandom % 2;
         ordy32 = ($urandom % 4) != 0;
         @(posedge clk); #1;
         cyc++;
      end
      iv16 = 0; iv32 = 0; ordy16 = 1; ordy32 = 1;
      repeat (6) begin
         @(posedge clk); #1;
      end
      chk("sweep_count", 64'(acc32 >= 10000), 64'd1);
      chk("drain16", 64'(q16.size()), 64'd0);
      chk("drain32", 64'(q32.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
